pmp: RTL and testbench
======================

# pmp

Combinational physical memory protection checker extended with domain-based memory protection (DMP), sitting between the MMU/LSU address path and memory in the core. For one physical address and access type it evaluates all PMP entries in priority order. It combines the winning entry's permissions with a per-entry domain tag against the current execution domain and produces a single allow/deny. A small registered fault-capture stage records denied accesses for debug and performance counting.

## Interface
- PLEN, 56: physical address width in bits.
- PMP_LEN, 54: width of each stored pmpaddr value (address bits [PMP_LEN+1:2]).
- NR_ENTRIES, 4: number of PMP/DMP entries, 0..16; 0 means always allow.
- clk_i  in  1  clock; fault-capture registers only.
- rst_i  in  1  synchronous, active-high reset.
- addr_i  in  PLEN  physical byte address to check.
- access_type_i  in  riscv::pmp_access_t (3)  requested access, one-hot R/W/X.
- priv_lvl_i  in  riscv::priv_lvl_t (2)  privilege of the access.
- curdom_i  in  riscv::dmp_domain_t (2)  current execution domain.
- conf_addr_i  in  NR_ENTRIES x PMP_LEN  pmpaddr values.
- pmpconf_i  in  NR_ENTRIES x riscv::pmpcfg_t (8)  pmpcfg values.
- dmpconf_i  in  NR_ENTRIES x riscv::dmpcfg_t (8)  dmpcfg values.
- allow_o  out  1  access permitted (combinational).
- fault_o  out  1  registered pulse: the previous cycle's access was denied.
- fault_addr_o  out  PLEN  address of the most recent denied access.
- fault_cnt_o  out  16  saturating count of denied accesses.

## Operation
- Access encodings: NONE=0, READ=1, WRITE=2, EXEC=4.
- Privilege encodings: U=0, S=1, M=3.
- Domain encodings: DOM0=0, DOM1=1, DOM2=2, DOMI=3. DOMI is the identity/privileged domain.
- pmpcfg_t layout: locked[7], reserved[6:5], addr_mode[4:3] (OFF=0, TOR=1, NA4=2, NAPOT=3), access_type[2:0].
- dmpcfg_t layout: reserved[7:2], domain[1:0].
- Address compared: a = addr_i[PMP_LEN+1:2]. Any addr_i bit above PMP_LEN+1 being set means no entry matches.
- Matching rules per entry i:
  - OFF: never matches.
  - TOR: matches when conf_addr[i-1] <= a < conf_addr[i]. For entry 0 the lower bound is 0.
  - NA4: matches when a == conf_addr[i].
  - NAPOT: k = number of trailing ones in conf_addr[i]. Region covers 2^(k+3) bytes. Matches when a and conf_addr[i] agree on bits [PMP_LEN-1:k+1].
  - NAPOT with all ones: matches the whole space.
- Priority: the lowest-index matching entry wins. Higher entries are ignored.
- Rule enforcement applies when priv_lvl_i != M, or when the winning entry is locked.
  - If enforced, allow_o = perm_ok && dom_ok.
  - If not enforced (M-mode, unlocked), allow_o = 1.
- perm_ok = (access_type_i & ~cfg.access_type) == 0.
- dom_ok = curdom_i==DOMI, or cfg.domain==DOMI, or cfg.domain==curdom_i.
- No matching entry: allow_o = 1 for M, 0 for S/U.
- NR_ENTRIES==0: allow_o = 1.
- access_type_i == NONE with a matching entry passes perm_ok.

## Timing
- allow_o is purely combinational from the inputs, with zero-cycle latency. It does not depend on reset.
- Fault capture updates on each clk_i rising edge. A denial is allow_o==0 with access_type_i != NONE. On a denial:
  - fault_o <= 1;
  - fault_addr_o <= addr_i;
  - fault_cnt_o <= fault_cnt_o+1, saturating at 0xFFFF.
- If there is no denial, fault_o <= 0 and the other fault registers hold.
- Reset has priority over capture in the same cycle: fault_o=0, fault_addr_o=0, fault_cnt_o=0.
- fault_o reflects the access one cycle earlier. There is no handshake; an access is checked every cycle.

## Structure
- riscv package holds: pmp_access_t, priv_lvl_t, pmpcfg_t, pmp_addr_mode_t, dmp_domain_t, dmpcfg_t, and the encodings above.
- One sub-module, pmp_entry, evaluates a single entry and outputs match_o. Parameters: PLEN, PMP_LEN. Inputs: addr, conf_addr, conf_addr_prev, addr_mode.
- The top module instantiates NR_ENTRIES of pmp_entry, then does the priority select, the permission and domain checks, and the fault-capture registers.

## Test plan
- NAPOT case:
  - Setup: PLEN=16, PMP_LEN=13, one entry, base 0x1900, size 2^8 (conf_addr=(0x1900>>2)|0x1F), RWX, U-mode, READ of 0x19BA.
  - Response: allow_o=1 for all 16 (curdom, cfg.domain) pairs except these, which give 0: DOM0/DOM1, DOM0/DOM2, DOM1/DOM0, DOM1/DOM2, DOM2/DOM0, DOM2/DOM1.
- Same NAPOT entry, READ of 0x1A00 (outside the region) in U-mode -> allow_o=0; the same access in M-mode -> allow_o=1.
- Permissions: cfg R only, domain DOMI, U-mode WRITE -> allow_o=0; READ -> allow_o=1. Set locked, M-mode WRITE -> allow_o=0.
- TOR and priority:
  - Entry0 TOR conf_addr=0x100 (R only); entry1 NAPOT covering the whole space, RWX.
  - U-mode WRITE to 0x3FC -> 0, because entry0 wins.
  - U-mode WRITE to 0x400 -> 1, from entry1.
- Fault capture:
  - Assert rst_i for one cycle -> fault outputs 0.
  - Three denied cycles at 0x0040 -> fault_o=1 the cycle after each; fault_addr_o=0x0040; fault_cnt_o=3.
  - Allowed cycle -> fault_o=0 and the count holds.
  - Reset asserted during a denial -> count 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for PMP/DMP checking: access types, privilege levels, domains, config bytes.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package riscv;

  typedef enum logic [2:0] {
    ACCESS_NONE  = 3'd0,
    ACCESS_READ  = 3'd1,
    ACCESS_WRITE = 3'd2,
    ACCESS_EXEC  = 3'd4
  } pmp_access_t;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'd0,
    PRIV_LVL_S = 2'd1,
    PRIV_LVL_M = 2'd3
  } priv_lvl_t;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    TOR   = 2'd1,
    NA4   = 2'd2,
    NAPOT = 2'd3
  } pmp_addr_mode_t;

  typedef enum logic [1:0] {
    DOM0 = 2'd0,
    DOM1 = 2'd1,
    DOM2 = 2'd2,
    DOMI = 2'd3
  } dmp_domain_t;

  // Permission field stays a plain vector: any R/W/X combination is legal here.
  typedef struct packed {
    logic           locked;
    logic [1:0]     reserved;
    pmp_addr_mode_t addr_mode;
    logic [2:0]     access_type;
  } pmpcfg_t;

  typedef struct packed {
    logic [5:0]  reserved;
    dmp_domain_t domain;
  } dmpcfg_t;

  // DOMI on either side acts as a wildcard; otherwise the domains must agree.
  function automatic logic dmp_dom_ok(input dmp_domain_t cur, input dmp_domain_t tag);
    return (cur == DOMI) || (tag == DOMI) || (tag == cur);
  endfunction

endpackage

// File: rtl/pmp_entry.sv
// Address match for a single PMP entry (OFF/TOR/NA4/NAPOT).
// Latency: combinational.
// Backpressure: none; evaluated every cycle.
module pmp_entry
  import riscv::*;
#(
  parameter int unsigned PLEN    = 56,
  parameter int unsigned PMP_LEN = 54
) (
  input  logic [PLEN-1:0]    addr,
  input  logic [PMP_LEN-1:0] conf_addr,
  input  logic [PMP_LEN-1:0] conf_addr_prev,
  input  pmp_addr_mode_t     addr_mode,
  output logic               match_o
);

  logic [PMP_LEN-1:0] a;
  logic               upper_ok;
  logic [PMP_LEN-1:0] napot_mask;
  logic               unused_lsb;

  assign a          = addr[PMP_LEN+1:2];
  assign unused_lsb = ^addr[1:0];

  // Address bits beyond the pmpaddr reach can never fall inside any region.
  if (PLEN > PMP_LEN + 2) begin : g_upper
    assign upper_ok = ~|addr[PLEN-1:PMP_LEN+2];
  end else begin : g_no_upper
    assign upper_ok = 1'b1;
  end

  // Trailing ones of conf_addr plus the first zero above them are "don't care" bits.
  always_comb begin
    logic run;
    napot_mask = '0;
    run        = 1'b1;
    for (int j = 0; j < int'(PMP_LEN); j++) begin
      napot_mask[j] = ~run;
      run           = run & conf_addr[j];
    end
  end

  // Region compare selected by the entry's addressing mode.
  always_comb begin
    match_o = 1'b0;
    unique case (addr_mode)
      OFF:     match_o = 1'b0;
      TOR:     match_o = (a >= conf_addr_prev) && (a < conf_addr);
      NA4:     match_o = (a == conf_addr);
      NAPOT:   match_o = (((a ^ conf_addr) & napot_mask) == '0);
      default: match_o = 1'b0;
    endcase
    match_o = match_o & upper_ok;
  end

endmodule

// File: rtl/pmp.sv
// PMP + domain checker: priority-selects the first matching entry and gates by permission and domain.
// Latency: allow_o combinational; fault_o/fault_addr_o/fault_cnt_o registered, one cycle after the access.
// Backpressure: none; one access is checked every cycle, denials are only recorded.
module pmp
  import riscv::*;
#(
  parameter int unsigned PLEN       = 56,
  parameter int unsigned PMP_LEN    = 54,
  parameter int unsigned NR_ENTRIES = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [PLEN-1:0]    addr_i,
  input  pmp_access_t        access_type_i,
  input  priv_lvl_t          priv_lvl_i,
  input  dmp_domain_t        curdom_i,
  input  logic [PMP_LEN-1:0] conf_addr_i [(NR_ENTRIES > 0) ? NR_ENTRIES : 1],
  input  pmpcfg_t            pmpconf_i   [(NR_ENTRIES > 0) ? NR_ENTRIES : 1],
  input  dmpcfg_t            dmpconf_i   [(NR_ENTRIES > 0) ? NR_ENTRIES : 1],
  output logic               allow_o,
  output logic               fault_o,
  output logic [PLEN-1:0]    fault_addr_o,
  output logic [15:0]        fault_cnt_o
);

  logic denied;

  if (NR_ENTRIES == 0) begin : g_none
    assign allow_o = 1'b1;
  end else begin : g_chk
    logic [NR_ENTRIES-1:0] match;
    logic                  hit;
    pmpcfg_t               win_cfg;
    dmp_domain_t           win_dom;
    logic                  enforce;
    logic                  perm_ok;
    logic                  dom_ok;
    logic                  unused_cfg;

    for (genvar i = 0; i < int'(NR_ENTRIES); i++) begin : g_entry
      logic [PMP_LEN-1:0] prev;
      if (i == 0) begin : g_first
        assign prev = '0;
      end else begin : g_rest
        assign prev = conf_addr_i[i-1];
      end

      pmp_entry #(
        .PLEN    (PLEN),
        .PMP_LEN (PMP_LEN)
      ) u_entry (
        .addr           (addr_i),
        .conf_addr      (conf_addr_i[i]),
        .conf_addr_prev (prev),
        .addr_mode      (pmpconf_i[i].addr_mode),
        .match_o        (match[i])
      );
    end

    // Lowest-index matching entry supplies the permissions and domain tag.
    always_comb begin
      hit     = 1'b0;
      win_cfg = '0;
      win_dom = DOM0;
      for (int i = 0; i < int'(NR_ENTRIES); i++) begin
        if (!hit && match[i]) begin
          hit     = 1'b1;
          win_cfg = pmpconf_i[i];
          win_dom = dmpconf_i[i].domain;
        end
      end
    end

    // Reserved config bits carry no meaning for the check.
    always_comb begin
      unused_cfg = 1'b0;
      for (int i = 0; i < int'(NR_ENTRIES); i++) begin
        unused_cfg = unused_cfg ^ (^pmpconf_i[i].reserved) ^ (^dmpconf_i[i].reserved);
      end
    end

    assign enforce = (priv_lvl_i != PRIV_LVL_M) || win_cfg.locked;
    assign perm_ok = ((access_type_i & ~win_cfg.access_type) == 3'b000);
    assign dom_ok  = dmp_dom_ok(curdom_i, win_dom);

    // Unmatched accesses are open to M-mode only; unlocked entries never restrict M-mode.
    always_comb begin
      if (!hit) begin
        allow_o = (priv_lvl_i == PRIV_LVL_M);
      end else if (enforce) begin
        allow_o = perm_ok && dom_ok;
      end else begin
        allow_o = 1'b1;
      end
    end
  end

  // NONE requests never count as denials even when allow_o is low.
  assign denied = ~allow_o && (access_type_i != ACCESS_NONE);

  // Fault capture: pulse, last denied address, saturating denial count; reset wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fault_o      <= 1'b0;
      fault_addr_o <= '0;
      fault_cnt_o  <= '0;
    end else if (denied) begin
      fault_o      <= 1'b1;
      fault_addr_o <= addr_i;
      if (fault_cnt_o != 16'hFFFF) begin
        fault_cnt_o <= fault_cnt_o + 16'd1;
      end
    end else begin
      fault_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pmp.sv
// Bench for pmp with a 16-bit physical address and four entries.
// Directed plan cases followed by randomized accesses against a region-arithmetic reference.
module tb_pmp;
  localparam int PLEN = 16;
  localparam int PMP_LEN = 13;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [PLEN-1:0] addr;
  logic [2:0]      acc;
  logic [1:0]      priv;
  logic [1:0]      dom;
  logic [PMP_LEN-1:0] ca [NR];
  logic [7:0]      pcb [NR];
  logic [7:0]      dcb [NR];
  riscv::pmpcfg_t  pc [NR];
  riscv::dmpcfg_t  dc [NR];

  logic            allow;
  logic            fault;
  logic [PLEN-1:0] fault_addr;
  logic [15:0]     fault_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  bit              ef;
  logic [PLEN-1:0] ea;
  int              ec;

  for (genvar g = 0; g < NR; g++) begin : g_cfg
    assign pc[g] = riscv::pmpcfg_t'(pcb[g]);
    assign dc[g] = riscv::dmpcfg_t'(dcb[g]);
  end

  always #5 clk = ~clk;

  pmp #(.PLEN(PLEN), .PMP_LEN(PMP_LEN), .NR_ENTRIES(NR)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .addr_i        (addr),
    .access_type_i (riscv::pmp_access_t'(acc)),
    .priv_lvl_i    (riscv::priv_lvl_t'(priv)),
    .curdom_i      (riscv::dmp_domain_t'(dom)),
    .conf_addr_i   (ca),
    .pmpconf_i     (pc),
    .dmpconf_i     (dc),
    .allow_o       (allow),
    .fault_o       (fault),
    .fault_addr_o  (fault_addr),
    .fault_cnt_o   (fault_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: each entry is turned into a byte range [lo, hi) and the address tested against it.
  function automatic bit ref_allow();
    longint a = longint'(addr);
    for (int i = 0; i < NR; i++) begin
      int     mode = int'(pcb[i][4:3]);
      bit     m = 0;
      longint lo = 0;
      longint hi = 0;
      if (a < (longint'(1) << (PMP_LEN + 2))) begin
        if (mode == 1) begin
          lo = (i == 0) ? 0 : longint'(ca[(i == 0) ? 0 : i - 1]) * 4;
          hi = longint'(ca[i]) * 4;
        end else if (mode == 2) begin
          lo = longint'(ca[i]) * 4;
          hi = lo + 4;
        end else if (mode == 3) begin
          int     k = 0;
          longint size;
          while (k < PMP_LEN && ca[i][k]) k++;
          size = longint'(1) << (k + 3);
          lo = (longint'(ca[i]) * 4) & ~(size - 1);
          hi = lo + size;
        end
        m = (mode != 0) && (a >= lo) && (a < hi);
      end
      if (m) begin
        if (priv != 2'd3 || pcb[i][7]) begin
          return ((acc & ~pcb[i][2:0]) == 3'b000) &&
                 (dom == 2'd3 || dcb[i][1:0] == 2'd3 || dcb[i][1:0] == dom);
        end
        return 1'b1;
      end
    end
    return priv == 2'd3;
  endfunction

  // Clock one edge, advance the fault-register reference, and compare after the edge.
  task automatic tick_check(input string tag);
    bit den;
    den = !ref_allow() && (acc != 3'd0);
    @(posedge clk);
    if (rst) begin
      ef = 0; ea = '0; ec = 0;
    end else if (den) begin
      ef = 1; ea = addr;
      if (ec < 16'hFFFF) ec++;
    end else begin
      ef = 0;
    end
    #1;
    chk({tag, ".fault"}, 64'(fault), 64'(ef));
    chk({tag, ".faddr"}, 64'(fault_addr), 64'(ea));
    chk({tag, ".fcnt"}, 64'(fault_cnt), 64'(ec));
    @(negedge clk);
  endtask

  task automatic all_off();
    for (int i = 0; i < NR; i++) begin
      ca[i] = '0; pcb[i] = 8'h00; dcb[i] = 8'h03;
    end
  endtask

  function automatic logic [2:0] rand_acc();
    int r = $urandom_range(0, 3);
    return (r == 0) ? 3'd0 : 3'(1 << (r - 1));
  endfunction

  initial begin
    rst = 1'b1; addr = '0; acc = 3'd1; priv = 2'd0; dom = 2'd0;
    all_off();
    @(negedge clk);
    tick_check("reset");
    rst = 1'b0;

    // NAPOT region 0x1900..0x19FF, RWX, domain pairs
    ca[0] = 13'h065F; pcb[0] = 8'h1F;
    addr = 16'h19BA; acc = 3'd1; priv = 2'd0;
    for (int cd = 0; cd < 4; cd++) begin
      for (int td = 0; td < 4; td++) begin
        bit exp_a;
        dom = 2'(cd); dcb[0] = 8'(td);
        exp_a = !((cd != td) && (cd != 3) && (td != 3));
        #1 chk($sformatf("napot_dom_%0d_%0d", cd, td), 64'(allow), 64'(exp_a));
        @(negedge clk);
      end
    end

    dom = 2'd0; dcb[0] = 8'h00;
    addr = 16'h1A00; priv = 2'd0;
    #1 chk("napot_outside_u", 64'(allow), 64'd0);
    @(negedge clk);
    priv = 2'd3;
    #1 chk("napot_outside_m", 64'(allow), 64'd1);
    @(negedge clk);

    // Permissions with R-only DOMI entry
    pcb[0] = 8'h19; dcb[0] = 8'h03; addr = 16'h19BA; priv = 2'd0; acc = 3'd2;
    #1 chk("perm_u_write", 64'(allow), 64'd0);
    @(negedge clk);
    acc = 3'd1;
    #1 chk("perm_u_read", 64'(allow), 64'd1);
    @(negedge clk);
    pcb[0] = 8'h99; priv = 2'd3; acc = 3'd2;
    #1 chk("perm_locked_m_write", 64'(allow), 64'd0);
    @(negedge clk);
    pcb[0] = 8'h19; acc = 3'd0; priv = 2'd0;
    #1 chk("perm_none", 64'(allow), 64'd1);
    @(negedge clk);

    // TOR priority over whole-space NAPOT
    all_off();
    ca[0] = 13'h0100; pcb[0] = 8'h09;
    ca[1] = 13'h1FFF; pcb[1] = 8'h1F;
    priv = 2'd0; acc = 3'd2; addr = 16'h03FC;
    #1 chk("tor_prio_3fc", 64'(allow), 64'd0);
    @(negedge clk);
    addr = 16'h0400;
    #1 chk("tor_prio_400", 64'(allow), 64'd1);
    @(negedge clk);
    addr = 16'h8000;
    #1 chk("upper_bit_nomatch", 64'(allow), 64'd0);
    @(negedge clk);

    // Fault capture
    all_off();
    priv = 2'd0; acc = 3'd1; addr = 16'h0040; rst = 1'b1;
    tick_check("f_reset");
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick_check($sformatf("f_deny%0d", n));
      chk("f_pulse", 64'(fault), 64'd1);
    end
    chk("f_addr3", 64'(fault_addr), 64'h0040);
    chk("f_cnt3", 64'(fault_cnt), 64'd3);
    priv = 2'd3;
    tick_check("f_allow");
    chk("f_allow_pulse", 64'(fault), 64'd0);
    chk("f_allow_hold", 64'(fault_cnt), 64'd3);
    priv = 2'd0; rst = 1'b1;
    tick_check("f_rst_deny");
    chk("f_rst_cnt", 64'(fault_cnt), 64'd0);
    rst = 1'b0;

    // Randomized accesses against the reference
    for (int it = 0; it < 400; it++) begin
      for (int i = 0; i < NR; i++) begin
        ca[i] = 13'($urandom_range(0, 8191));
        if ($urandom_range(0, 1) == 1) ca[i] = ca[i] | 13'((1 << $urandom_range(0, 13)) - 1);
        pcb[i] = 8'($urandom);
        dcb[i] = 8'($urandom);
      end
      if ($urandom_range(0, 3) != 0) addr = 16'({ca[$urandom_range(0, NR - 1)], 2'b00} + $urandom_range(0, 300));
      else addr = 16'($urandom);
      acc  = rand_acc();
      priv = ($urandom_range(0, 2) == 2) ? 2'd3 : 2'($urandom_range(0, 1));
      dom  = 2'($urandom_range(0, 3));
      rst  = ($urandom_range(0, 29) == 0);
      #1 chk($sformatf("rand_allow_%0d", it), 64'(allow), 64'(ref_allow()));
      tick_check($sformatf("rand_%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
